// File: rtl/video_vga_timing_out.sv
// 640x480@60 VGA raster generator that drains an Avalon-ST pixel stream in lockstep
// with the active area, aligning start-of-packet to the raster origin.
module video_vga_timing_out #(
    parameter int DATA_WIDTH      = 24,
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  in_ready,
    input  logic                  clr_status,
    output logic [DATA_WIDTH-1:0] vga_rgb,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_de,
    output logic [11:0]           vga_x,
    output logic [11:0]           vga_y,
    output logic                  underflow,
    output logic                  frame_err
);
    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic        SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {WAIT_LOCK, SYNC, RUN} state_t;

    state_t      state, state_nxt;
    logic        lock_meta, lock_s;
    logic [11:0] h_cnt, v_cnt;
    logic        hold, active, origin, last_px, hs_on, vs_on;
    logic        take, set_uf, set_fe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Losing lock forces everything back to the idle raster on the next edge.
    assign hold    = !lock_s || (state == WAIT_LOCK);
    assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign origin  = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    assign last_px = (h_cnt == H_ACT - 12'd1) && (v_cnt == V_ACT - 12'd1);
    assign hs_on   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs_on   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (hold) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_LOCK;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        take      = 1'b0;
        set_uf    = 1'b0;
        set_fe    = 1'b0;
        if (!lock_s) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: state_nxt = SYNC;
                SYNC: begin
                    // Flush non-sop beats; park a sop beat until the raster origin.
                    if (in_valid && in_sop) begin
                        if (origin) begin
                            in_ready  = 1'b1;
                            take      = 1'b1;
                            state_nxt = RUN;
                        end
                    end else begin
                        in_ready = 1'b1;
                    end
                end
                RUN: begin
                    in_ready = active && !(in_sop && !origin);
                    if (active) begin
                        if (!in_valid) begin
                            set_uf    = 1'b1;
                            state_nxt = SYNC;
                        end else if (in_sop && !origin) begin
                            set_fe    = 1'b1;
                            state_nxt = SYNC;
                        end else begin
                            take   = 1'b1;
                            set_fe = (in_eop != last_px);
                        end
                    end
                end
                default: state_nxt = WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_rgb <= '0;
            vga_de  <= 1'b0;
            vga_hs  <= SYNC_IDLE;
            vga_vs  <= SYNC_IDLE;
            vga_x   <= '0;
            vga_y   <= '0;
        end else if (hold) begin
            vga_rgb <= '0;
            vga_de  <= 1'b0;
            vga_hs  <= SYNC_IDLE;
            vga_vs  <= SYNC_IDLE;
            vga_x   <= '0;
            vga_y   <= '0;
        end else begin
            vga_rgb <= take ? in_data : '0;
            vga_de  <= active;
            vga_hs  <= hs_on ? ~SYNC_IDLE : SYNC_IDLE;
            vga_vs  <= vs_on ? ~SYNC_IDLE : SYNC_IDLE;
            vga_x   <= h_cnt;
            vga_y   <= v_cnt;
        end
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            underflow <= set_uf || (underflow && !clr_status);
            frame_err <= set_fe || (frame_err && !clr_status);
        end
    end

endmodule

// File: tb/tb_video_vga_timing_out.sv
// Directed bench for video_vga_timing_out on a shrunken 16x8 raster (8x4 active).
module tb_video_vga_timing_out;
    localparam int DW = 24;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int NPIX = HA * VA;

    logic          clk = 1'b0;
    logic          reset_n, pll_locked, in_valid, in_sop, in_eop, in_ready, clr_status;
    logic [DW-1:0] in_data, vga_rgb;
    logic          vga_hs, vga_vs, vga_de, underflow, frame_err;
    logic [11:0]   vga_x, vga_y;

    always #20 clk = ~clk;

    video_vga_timing_out #(
        .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready), .clr_status(clr_status),
        .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_x(vga_x), .vga_y(vga_y), .underflow(underflow), .frame_err(frame_err)
    );

    int   total = 0, bad = 0;
    int   pidx = 0, drop_idx = 0, inj_idx = 0;
    bit   src_on = 0, drop_arm = 0, inj_arm = 0, inj_chk = 0, clr_force = 0, xfer = 0;
    int   n_good, n_black, n_de, n_hs, n_vs, n_xfer;
    logic inj_ready;

    function automatic logic [DW-1:0] pat(input int x, input int y);
        return {8'(y), 8'(x), 8'hA5};
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Source walks frame pixels in raster order; advances only on handshake.
    task automatic drive();
        bit drop;
        drop       = drop_arm && (pidx == drop_idx);
        in_valid   = src_on && !drop;
        in_data    = pat(pidx % HA, pidx / HA);
        in_sop     = (pidx == 0);
        in_eop     = (pidx == NPIX - 1);
        clr_status = clr_force || (src_on && drop);
    endtask

    task automatic clear_stats();
        n_good = 0; n_black = 0; n_de = 0; n_hs = 0; n_vs = 0; n_xfer = 0;
    endtask

    task automatic tally();
        if (vga_de === 1'b1) begin
            n_de++;
            if (vga_rgb === pat(int'(vga_x), int'(vga_y))) n_good++;
            else if (vga_rgb === '0) n_black++;
        end
        if (vga_hs === 1'b0) n_hs++;
        if (vga_vs === 1'b0) n_vs++;
        if (xfer) n_xfer++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (xfer) pidx = (pidx + 1) % NPIX;
        if (inj_arm && pidx == inj_idx) begin
            pidx = 0; inj_arm = 0; inj_chk = 1;
        end
        drive();
        @(negedge clk);
        xfer = (in_ready === 1'b1) && (in_valid === 1'b1);
        if (inj_chk) begin inj_ready = in_ready; inj_chk = 0; end
        if (drop_arm && src_on && pidx == drop_idx) drop_arm = 0;
        tally();
    endtask

    task automatic wait_xy(input string tag, input int x, input int y);
        int k = 0;
        tick();
        while (!(int'(vga_x) == x && int'(vga_y) == y) && k < 2 * FRAME) begin tick(); k++; end
        check(tag, longint'(k < 2 * FRAME), 1);
    endtask

    // One full frame window starting at the cycle that shows output pixel (0,0).
    task automatic run_frame(input string tag);
        int k = 0;
        tick();
        while (!(vga_de === 1'b1 && vga_x == 12'd0 && vga_y == 12'd0) && k < 3 * FRAME) begin
            tick(); k++;
        end
        check({tag, "_origin"}, longint'(k < 3 * FRAME), 1);
        clear_stats();
        tally();
        repeat (FRAME - 1) tick();
    endtask

    initial begin
        reset_n = 1'b0; pll_locked = 1'b0; inj_ready = 1'b1;
        drive(); clear_stats();
        repeat (3) tick();
        check("rst_de", vga_de, 0);
        check("rst_rgb", vga_rgb, 0);
        check("rst_xy", {vga_x, vga_y}, 0);
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_ready", in_ready, 0);
        check("rst_flags", {underflow, frame_err}, 0);

        reset_n = 1'b1;
        repeat (5) tick();
        check("nolock_de", vga_de, 0);
        check("nolock_x", vga_x, 0);

        pll_locked = 1'b1;
        repeat (3) tick();
        check("lock_sync_de", vga_de, 0);
        tick();
        check("lock_first_de", vga_de, 1);
        check("lock_first_x", vga_x, 0);
        tick();
        check("lock_second_x", vga_x, 1);

        run_frame("sync");
        check("sync_de", n_de, NPIX);
        check("sync_black", n_black, NPIX);
        check("sync_hs_low", n_hs, VT * HS);
        check("sync_vs_low", n_vs, VS * HT);
        check("sync_xfer", n_xfer, 0);

        wait_xy("hs_pre_pos", HA + HF - 1, 0);
        check("hs_pre_lvl", vga_hs, 1);
        tick();
        check("hs_start_lvl", vga_hs, 0);
        repeat (HS) tick();
        check("hs_end_x", vga_x, HA + HF + HS);
        check("hs_end_lvl", vga_hs, 1);
        wait_xy("vs_start_pos", 0, VA + VF);
        check("vs_start_lvl", vga_vs, 0);
        wait_xy("vs_end_pos", 0, VA + VF + VS);
        check("vs_end_lvl", vga_vs, 1);

        // Stream joins mid-frame: 20 non-sop beats flushed, then sop parked.
        pidx = 12; src_on = 1; clear_stats();
        repeat (21) tick();
        check("disc_xfer", n_xfer, 20);
        check("disc_good", n_good, 0);
        check("hold_sop", in_sop, 1);
        check("hold_ready", in_ready, 0);

        run_frame("run1");
        check("run1_good", n_good, NPIX);
        check("run1_xfer", n_xfer, NPIX);
        check("run1_flags", {underflow, frame_err}, 0);
        run_frame("run2");
        check("run2_good", n_good, NPIX);
        check("run2_flags", {underflow, frame_err}, 0);

        // Starve pixel (3,2); clear pulsed in the same cycle must lose.
        drop_idx = 3 + 2 * HA; drop_arm = 1;
        run_frame("uf");
        check("uf_good", n_good, 19);
        check("uf_black", n_black, NPIX - 19);
        check("uf_flag", underflow, 1);
        check("uf_fe", frame_err, 0);
        run_frame("uf_resync");
        check("uf_resync_good", n_good, NPIX);

        // Early sop at (5,1).
        inj_idx = 5 + HA; inj_arm = 1; inj_ready = 1'b1;
        run_frame("inj");
        check("inj_good", n_good, 13);
        check("inj_black", n_black, NPIX - 13);
        check("inj_ready", inj_ready, 0);
        check("inj_fe", frame_err, 1);
        run_frame("inj_resync");
        check("inj_resync_good", n_good, NPIX);

        wait_xy("loss_pos", 4, 1);
        pll_locked = 1'b0;
        repeat (3) tick();
        check("loss_de", vga_de, 0);
        check("loss_rgb", vga_rgb, 0);
        check("loss_xy", {vga_x, vga_y}, 0);
        check("loss_syncs", {vga_hs, vga_vs}, 3);
        check("loss_ready", in_ready, 0);
        check("loss_flags_kept", {underflow, frame_err}, 3);
        repeat (5) tick();
        check("loss_idle_x", vga_x, 0);

        pll_locked = 1'b1;
        run_frame("relock1");
        check("relock1_good", n_good, 0);
        run_frame("relock2");
        check("relock2_good", n_good, NPIX);
        check("relock2_xfer", n_xfer, NPIX);

        clr_force = 1; tick();
        clr_force = 0; tick();
        check("clr_flags", {underflow, frame_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
